// File: rtl/fdiv_if.sv
// Purpose: groups the divider command, operand and result signals into one bundle.
// Latency: none, wiring only.
// Backpressure: none; the requester watches busy/done and holds start until idle.
`timescale 1ns/1ps
interface fdiv_if;
    logic       start;
    logic       load;
    logic [9:0] A;
    logic [9:0] B;
    logic [9:0] F;
    logic       done;
    logic       busy;
    logic       ovf;
    logic       udf;
    logic       dbz;

    modport master (
        output start, load, A, B,
        input  F, done, busy, ovf, udf, dbz
    );

    modport slave (
        input  start, load, A, B,
        output F, done, busy, ovf, udf, dbz
    );
endinterface

// File: rtl/fdiv.sv
// Purpose: sequential divider for a sign / 5-bit 0.m mantissa / 4-bit exponent float format.
// Latency: done is high in the cycle after edge 6+n from the start edge; zero operands take the path after edge 1.
// Backpressure: start and load are only honoured in IDLE; busy is high while an operation is in flight.
`timescale 1ns/1ps
module fdiv (
    input  logic  clk,
    input  logic  rstn,
    fdiv_if.slave io
);
    typedef enum logic [1:0] {IDLE, NORM, DIV, DONE} state_t;

    state_t            state, state_nxt;
    logic              sa, sb;
    logic [4:0]        ma, mb;
    logic signed [6:0] ea, eb;
    logic [5:0]        rem;
    logic [3:0]        q;
    logic [2:0]        cnt;
    logic signed [7:0] er;
    logic [9:0]        f_r;
    logic              ovf_r, udf_r, dbz_r;

    logic              a_zero, b_zero, norm_ok, m_ge, rem_ge, sign;
    logic [4:0]        rem_sub;
    logic              set_res;
    logic [9:0]        res_f;
    logic              res_ovf, res_udf, res_dbz;

    assign a_zero  = (ma == 5'd0);
    assign b_zero  = (mb == 5'd0);
    assign norm_ok = ma[4] & mb[4];
    assign m_ge    = (ma >= mb);
    assign sign    = sa ^ sb;
    // Remainder never reaches 2*mb, so after a subtract it fits in 5 bits.
    assign rem_ge  = (rem >= {1'b0, mb});
    assign rem_sub = rem_ge ? 5'(rem - {1'b0, mb}) : rem[4:0];

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state and the result that is latched on entry to DONE.
    always_comb begin
        state_nxt = state;
        set_res   = 1'b0;
        res_f     = 10'd0;
        res_ovf   = 1'b0;
        res_udf   = 1'b0;
        res_dbz   = 1'b0;
        case (state)
            IDLE: if (io.start) state_nxt = NORM;
            NORM: begin
                if (b_zero) begin
                    state_nxt = DONE;
                    set_res   = 1'b1;
                    res_dbz   = 1'b1;
                    res_f     = {sign, 5'b11111, 4'b0111};
                end else if (a_zero) begin
                    state_nxt = DONE;
                    set_res   = 1'b1;
                    res_f     = 10'b0_00000_1000;
                end else if (norm_ok) begin
                    state_nxt = DIV;
                end
            end
            DIV: begin
                if (cnt == 3'd4) begin
                    state_nxt = DONE;
                    set_res   = 1'b1;
                    if (er > 8'sd7) begin
                        res_ovf = 1'b1;
                        res_f   = {sign, 5'b11111, 4'b0111};
                    end else if (er < -8'sd8) begin
                        res_udf = 1'b1;
                        res_f   = 10'b0_00000_1000;
                    end else begin
                        res_f   = {sign, q, rem_ge, er[3:0]};
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture in IDLE and left-normalisation during NORM.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sa <= 1'b0; ma <= 5'd0; ea <= 7'sd0;
            sb <= 1'b0; mb <= 5'd0; eb <= 7'sd0;
        end else if (state == IDLE && io.load) begin
            sa <= io.A[9]; ma <= io.A[8:4]; ea <= {{3{io.A[3]}}, io.A[3:0]};
            sb <= io.B[9]; mb <= io.B[8:4]; eb <= {{3{io.B[3]}}, io.B[3:0]};
        end else if (state == NORM && !a_zero && !b_zero && !norm_ok) begin
            if (!ma[4]) begin
                ma <= {ma[3:0], 1'b0};
                ea <= ea - 7'sd1;
            end
            if (!mb[4]) begin
                mb <= {mb[3:0], 1'b0};
                eb <= eb - 7'sd1;
            end
        end
    end

    // Restoring divider: pre-scale the dividend so the first quotient bit is always 1.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rem <= 6'd0; q <= 4'd0; cnt <= 3'd0; er <= 8'sd0;
        end else if (state == NORM && norm_ok) begin
            rem <= m_ge ? {1'b0, ma} : {ma, 1'b0};
            er  <= {ea[6], ea} - {eb[6], eb} + {7'd0, m_ge};
            q   <= 4'd0;
            cnt <= 3'd0;
        end else if (state == DIV) begin
            rem <= {rem_sub, 1'b0};
            q   <= {q[2:0], rem_ge};
            cnt <= cnt + 3'd1;
        end
    end

    // Result and flags: cleared on an accepted start, held from DONE until the next one.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            f_r <= 10'd0; ovf_r <= 1'b0; udf_r <= 1'b0; dbz_r <= 1'b0;
        end else if (state == IDLE && io.start) begin
            f_r <= 10'd0; ovf_r <= 1'b0; udf_r <= 1'b0; dbz_r <= 1'b0;
        end else if (set_res) begin
            f_r <= res_f; ovf_r <= res_ovf; udf_r <= res_udf; dbz_r <= res_dbz;
        end
    end

    assign io.F    = f_r;
    assign io.ovf  = ovf_r;
    assign io.udf  = udf_r;
    assign io.dbz  = dbz_r;
    assign io.done = (state == DONE);
    assign io.busy = (state != IDLE);
endmodule

// File: tb/tb_fdiv.sv
// Purpose: self-checking bench for fdiv with an arithmetic reference model and expected-result queue.
// Latency: each operation is bounded to 60 cycles.
// Backpressure: operations are issued only while the divider is idle.
`timescale 1ns/1ps
module tb_fdiv;
    logic clk;
    logic rstn;
    fdiv_if io ();

    fdiv dut (
        .clk  (clk),
        .rstn (rstn),
        .io   (io)
    );

    typedef struct {
        logic [9:0] f;
        logic       ovf;
        logic       udf;
        logic       dbz;
        int         lat;
    } exp_t;

    exp_t       sb_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [9:0] cur_a = 10'd0;
    logic [9:0] cur_b = 10'd0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: normalise by doubling, divide with integer arithmetic, then range-check.
    function automatic exp_t model(input logic [9:0] a, input logic [9:0] b);
        exp_t r;
        int ma, mb, ea, eb, na, nb, qv, e;
        logic s;
        logic [4:0] qm;
        logic [3:0] em;
        r.f = 10'd0; r.ovf = 1'b0; r.udf = 1'b0; r.dbz = 1'b0; r.lat = 2;
        s  = a[9] ^ b[9];
        ma = int'(a[8:4]);
        mb = int'(b[8:4]);
        ea = int'($signed(a[3:0]));
        eb = int'($signed(b[3:0]));
        if (mb == 0) begin
            r.dbz = 1'b1;
            r.f   = {s, 5'b11111, 4'b0111};
        end else if (ma == 0) begin
            r.f   = 10'b0_00000_1000;
        end else begin
            na = 0; nb = 0;
            while (ma < 16) begin ma = ma * 2; ea = ea - 1; na++; end
            while (mb < 16) begin mb = mb * 2; eb = eb - 1; nb++; end
            if (ma < mb) begin qv = (ma * 32) / mb; e = ea - eb; end
            else         begin qv = (ma * 16) / mb; e = ea - eb + 1; end
            r.lat = 7 + ((na > nb) ? na : nb);
            if (e > 7) begin
                r.ovf = 1'b1;
                r.f   = {s, 5'b11111, 4'b0111};
            end else if (e < -8) begin
                r.udf = 1'b1;
                r.f   = 10'b0_00000_1000;
            end else begin
                qm  = qv[4:0];
                em  = e[3:0];
                r.f = {s, qm, em};
            end
        end
        return r;
    endfunction

    // Issue one operation, optionally loading new operands in the start cycle,
    // optionally pulsing a stray load while busy, then compare against the queue.
    task automatic run_op(input logic [9:0] a, input logic [9:0] b,
                          input bit do_load, input bit stray_load);
        exp_t e;
        int   cnt;
        logic [9:0] f_done;
        @(negedge clk);
        if (do_load) begin
            io.load = 1'b1; io.A = a; io.B = b;
            cur_a = a; cur_b = b;
        end
        io.start = 1'b1;
        sb_q.push_back(model(cur_a, cur_b));
        cnt = 0;
        @(posedge clk); cnt++;
        @(negedge clk);
        io.start = 1'b0; io.load = 1'b0;
        check("start_clr_f", {22'd0, io.F}, 32'd0);
        check("start_clr_flags", {29'd0, io.ovf, io.udf, io.dbz}, 32'd0);
        check("start_busy", {31'd0, io.busy}, 32'd1);
        while (!io.done && cnt < 60) begin
            @(posedge clk); cnt++;
            @(negedge clk);
            if (stray_load && cnt == 3) begin
                io.load = 1'b1; io.A = 10'b1_11111_0011; io.B = 10'b0_00001_0010;
            end else begin
                io.load = 1'b0;
            end
        end
        io.load = 1'b0;
        e = sb_q.pop_front();
        check("latency", cnt, e.lat);
        check("result_f", {22'd0, io.F}, {22'd0, e.f});
        check("flags", {29'd0, io.ovf, io.udf, io.dbz}, {29'd0, e.ovf, e.udf, e.dbz});
        f_done = io.F;
        @(posedge clk);
        @(negedge clk);
        check("done_one_cycle", {30'd0, io.done, io.busy}, 32'd0);
        check("f_held", {22'd0, io.F}, {22'd0, f_done});
    endtask

    initial begin
        int seen;
        io.start = 1'b0; io.load = 1'b0; io.A = 10'd0; io.B = 10'd0;
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outputs", {20'd0, io.F, io.done, io.busy},  32'd0);
        check("rst_flags", {29'd0, io.ovf, io.udf, io.dbz}, 32'd0);
        rstn = 1'b1;

        run_op(10'b0_10000_0001, 10'b0_10000_0001, 1, 0);   // 1/1
        run_op(10'b0_11000_0000, 10'b1_10000_0000, 1, 0);   // -1.5
        run_op(10'b0_00100_0000, 10'b0_10000_0000, 1, 0);   // three NORM cycles
        run_op(10'b0_10000_0111, 10'b0_10000_1000, 1, 0);   // overflow
        run_op(10'b0_10000_1000, 10'b0_11000_0111, 1, 0);   // underflow
        run_op(10'b0_10100_0000, 10'b1_00000_0011, 1, 0);   // divide by zero
        run_op(10'b0_00000_0000, 10'b1_00000_0000, 1, 0);   // 0/0 still dbz
        run_op(10'b1_00000_0101, 10'b1_10000_0000, 1, 0);   // zero result, sign 0
        run_op(10'b1_10111_0010, 10'b0_11101_1110, 1, 0);   // Ma < Mb
        run_op(10'b0_00001_0111, 10'b0_00011_0001, 1, 0);   // both operands shift

        // Operands loaded ahead of start, then different bus values without load.
        @(negedge clk);
        io.load = 1'b1; io.A = 10'b0_11010_0010; io.B = 10'b0_10110_1111;
        cur_a = io.A; cur_b = io.B;
        @(negedge clk);
        io.load = 1'b0; io.A = 10'b0_00000_0000; io.B = 10'b0_00000_0000;
        run_op(10'd0, 10'd0, 0, 1);   // stray load while busy must be ignored
        run_op(10'd0, 10'd0, 0, 0);   // same operands reused

        for (int i = 0; i < 16; i++) begin
            run_op(10'($urandom), 10'($urandom), 1, 0);
        end

        // Reset during DIV: outputs drop at once and no done pulse follows.
        @(negedge clk);
        io.load = 1'b1; io.A = 10'b0_10000_0001; io.B = 10'b0_11000_0001;
        io.start = 1'b1;
        repeat (4) @(negedge clk);
        io.load = 1'b0; io.start = 1'b0;
        rstn = 1'b0;
        #1;
        check("abort_outputs", {20'd0, io.F, io.done, io.busy}, 32'd0);
        check("abort_flags", {29'd0, io.ovf, io.udf, io.dbz}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        cur_a = 10'd0; cur_b = 10'd0;
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (io.done || io.busy) seen++;
        end
        check("abort_no_done", seen, 0);

        // Without a fresh load the cleared operands divide 0 by 0.
        run_op(10'd0, 10'd0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
